no_ativo: RTL and testbench
===========================

# no_ativo

Per-slot active-node agent: the responder side of the active-node manager's enable/address/active handshake. One instance per slot (NUM_NA instances), each driving one lane of the manager's packed `na_endereco_in` / `na_ativo_in` buses and consuming one bit of its one-hot `habilitar_out`. When enabled while free, the agent captures a node address and tentative cost, holds them while active, relaxes the cost on matching update broadcasts, and frees itself on a matching deactivate broadcast.

## Interface

Parameters:
- ADR_WIDTH, 5, node address width
- CUSTO_WIDTH, 8, cost width (unsigned)
- TIMEOUT_CYCLES, 64, idle cycles before auto-release (used only with NO_ATIVO_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset rst_n, asynchronous, active-high
- habilitar_in  in  1  load strobe from manager (this slot's `habilitar_out` bit)
- atualizar_in  in  1  update broadcast strobe
- desativar_in  in  1  deactivate broadcast strobe
- endereco_in  in  ADR_WIDTH  broadcast node address
- custo_in  in  CUSTO_WIDTH  broadcast tentative cost
- na_ativo_out  out  1  slot occupied; drives manager `na_ativo_in[i]`
- na_endereco_out  out  ADR_WIDTH  held address; drives lane i of manager `na_endereco_in`
- na_custo_out  out  CUSTO_WIDTH  held cost
- atualizado_out  out  1  one-cycle pulse: cost lowered
- erro_out  out  1  one-cycle pulse: habilitar_in while not LIVRE
- expirou_out  out  1  one-cycle pulse: timeout release

## Operation

- FSM states: LIVRE, ATIVO. Reset → LIVRE.
- match = (state == ATIVO) && (endereco_in == na_endereco_out).
- LIVRE + habilitar_in → ATIVO; capture endereco_in, custo_in.
- ATIVO + desativar_in + match → LIVRE; na_endereco_out, na_custo_out cleared to 0.
- ATIVO + atualizar_in + match + (custo_in < na_custo_out) → na_custo_out ← custo_in, atualizado_out pulses. Equal or greater cost: no change, no pulse.
- Non-matching atualizar/desativar: ignored.
- habilitar_in in ATIVO: ignored (held data unchanged), erro_out pulses.
- Priority in same cycle: desativar (match) > atualizar (match). habilitar_in in LIVRE with desativar_in/atualizar_in: load wins (no match possible in LIVRE).
- Comparison strictly unsigned, CUSTO_WIDTH bits; no saturation or wrap arithmetic inside the block.

## Timing

- All outputs registered. Reset values: na_ativo_out 0, na_endereco_out 0, na_custo_out 0, all pulses 0.
- habilitar_in sampled at edge N → na_ativo_out, na_endereco_out, na_custo_out valid after edge N (1-cycle latency). The manager's rising-edge detection on na_ativo_out relies on this.
- Update/deactivate: effect visible after the sampling edge; pulses high for exactly one cycle.
- Strobes are level-sampled each cycle; a strobe held for k cycles is k events (repeat habilitar_in in ATIVO → k erro_out pulses).
- rst_n asserted mid-operation: immediate return to LIVRE with all outputs at reset value; in-flight strobe discarded.

## Configuration

- NO_ATIVO_TIMEOUT_EN defined: watchdog counter of width $clog2(TIMEOUT_CYCLES). Cleared on entry to ATIVO and on any matching atualizar_in (improving or not); increments each ATIVO cycle otherwise. At count TIMEOUT_CYCLES-1 with no matching strobe → LIVRE, outputs cleared, expirou_out pulses. Matching desativar in the same cycle → normal release, no expirou_out.
- Not defined: counter absent, expirou_out tied 0, slot stays ATIVO until desativar.

## Structure

- Package no_ativo_pkg: state enum (LIVRE, ATIVO), default ADR_WIDTH/CUSTO_WIDTH localparams shared with the manager.
- Sub-module no_ativo_watchdog: timeout counter, instantiated only under NO_ATIVO_TIMEOUT_EN; inputs clear/run, output expire.

## Test plan

- Reset: rst_n=1 → all outputs 0; release, idle 5 cycles → still 0.
- Load: habilitar_in=1, endereco_in=5, custo_in=20 one cycle → next cycle na_ativo_out=1, na_endereco_out=5, na_custo_out=20.
- Relax: atualizar addr 5 cost 12 → na_custo_out=12, atualizado_out one pulse; then cost 15 → unchanged, no pulse; addr 9 cost 1 → unchanged.
- Collision and priority: in ATIVO, habilitar_in with addr 7 → erro_out pulse, address stays 5; same-cycle atualizar+desativar addr 5 → LIVRE, outputs 0, no atualizado_out.
- Reset mid-operation: ATIVO addr 5, assert rst_n between edges → outputs 0 immediately, state LIVRE.
- Timeout (macro on, TIMEOUT_CYCLES=8): load addr 3, no strobes → na_ativo_out falls after 8th ATIVO cycle with expirou_out pulse; matching atualizar at cycle 6 delays release by 6 cycles. Macro off: no release after 100 cycles.

Source files
------------

// File: rtl/no_ativo_pkg.sv
// Shared types and default widths for the active-node agent and its manager.
package no_ativo_pkg;

  typedef enum logic [0:0] {
    LIVRE = 1'b0,
    ATIVO = 1'b1
  } estado_t;

  localparam int ADR_WIDTH_DEF   = 5;
  localparam int CUSTO_WIDTH_DEF = 8;

endpackage

// File: rtl/no_ativo_watchdog.sv
// Idle watchdog for an occupied slot; asserts expire on the last idle cycle.
// Instantiated by no_ativo only when NO_ATIVO_TIMEOUT_EN is defined.
module no_ativo_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count sits at zero while the slot is free, so entry into ATIVO starts from 0.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
    end else if (clear || !run || expire) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign expire = run && !clear && (count == LAST);

endmodule

// File: rtl/no_ativo.sv
// Per-slot active-node agent: captures an address/cost on enable, relaxes cost on
// matching updates, frees on matching deactivate. NO_ATIVO_TIMEOUT_EN adds idle auto-release.
module no_ativo
  import no_ativo_pkg::*;
#(
  parameter int ADR_WIDTH      = ADR_WIDTH_DEF,
  parameter int CUSTO_WIDTH    = CUSTO_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   habilitar_in,
  input  logic                   atualizar_in,
  input  logic                   desativar_in,
  input  logic [ADR_WIDTH-1:0]   endereco_in,
  input  logic [CUSTO_WIDTH-1:0] custo_in,
  output logic                   na_ativo_out,
  output logic [ADR_WIDTH-1:0]   na_endereco_out,
  output logic [CUSTO_WIDTH-1:0] na_custo_out,
  output logic                   atualizado_out,
  output logic                   erro_out,
  output logic                   expirou_out
);

  estado_t                state_q, state_d;
  logic [ADR_WIDTH-1:0]   addr_d;
  logic [CUSTO_WIDTH-1:0] cost_d;
  logic                   atual_d, erro_d, expir_d;
  logic                   match;
  logic                   expire;

  assign match = (state_q == ATIVO) && (endereco_in == na_endereco_out);

`ifdef NO_ATIVO_TIMEOUT_EN
  no_ativo_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (match && (atualizar_in || desativar_in)),
    .run   (state_q == ATIVO),
    .expire(expire)
  );
`else
  // Without the watchdog the slot never self-releases; TIMEOUT_CYCLES is inert.
  assign expire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q         <= LIVRE;
      na_endereco_out <= '0;
      na_custo_out    <= '0;
      atualizado_out  <= 1'b0;
      erro_out        <= 1'b0;
      expirou_out     <= 1'b0;
    end else begin
      state_q         <= state_d;
      na_endereco_out <= addr_d;
      na_custo_out    <= cost_d;
      atualizado_out  <= atual_d;
      erro_out        <= erro_d;
      expirou_out     <= expir_d;
    end
  end

  assign na_ativo_out = (state_q == ATIVO);

  always_comb begin
    state_d = state_q;
    addr_d  = na_endereco_out;
    cost_d  = na_custo_out;
    atual_d = 1'b0;
    erro_d  = 1'b0;
    expir_d = 1'b0;
    unique case (state_q)
      LIVRE: begin
        if (habilitar_in) begin
          state_d = ATIVO;
          addr_d  = endereco_in;
          cost_d  = custo_in;
        end
      end
      ATIVO: begin
        erro_d = habilitar_in;
        // Deactivate outranks update; expiry only fires with no matching strobe.
        if (match && desativar_in) begin
          state_d = LIVRE;
          addr_d  = '0;
          cost_d  = '0;
        end else if (match && atualizar_in && (custo_in < na_custo_out)) begin
          cost_d  = custo_in;
          atual_d = 1'b1;
        end else if (expire) begin
          state_d = LIVRE;
          addr_d  = '0;
          cost_d  = '0;
          expir_d = 1'b1;
        end
      end
      default: state_d = LIVRE;
    endcase
  end

endmodule

// File: tb/tb_no_ativo.sv
// Directed bench for no_ativo; exercises the timeout path when NO_ATIVO_TIMEOUT_EN is defined.
module tb_no_ativo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       habilitar_in, atualizar_in, desativar_in;
  logic [4:0] endereco_in;
  logic [7:0] custo_in;
  logic       na_ativo_out;
  logic [4:0] na_endereco_out;
  logic [7:0] na_custo_out;
  logic       atualizado_out, erro_out, expirou_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  no_ativo #(
    .ADR_WIDTH(5),
    .CUSTO_WIDTH(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .habilitar_in   (habilitar_in),
    .atualizar_in   (atualizar_in),
    .desativar_in   (desativar_in),
    .endereco_in    (endereco_in),
    .custo_in       (custo_in),
    .na_ativo_out   (na_ativo_out),
    .na_endereco_out(na_endereco_out),
    .na_custo_out   (na_custo_out),
    .atualizado_out (atualizado_out),
    .erro_out       (erro_out),
    .expirou_out    (expirou_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    habilitar_in = 1'b0;
    atualizar_in = 1'b0;
    desativar_in = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    endereco_in = '0;
    custo_in    = '0;
    rst_n = 1'b1;
    tick();
    tick();
    tests++; if ({na_ativo_out, na_endereco_out, na_custo_out, atualizado_out, erro_out, expirou_out} !== 16'h0) begin
      fails++; $display("FAIL reset_outputs got %h exp 0", {na_ativo_out, na_endereco_out, na_custo_out, atualizado_out, erro_out, expirou_out});
    end
    rst_n = 1'b0;
    repeat (5) tick();
    tests++; if ({na_ativo_out, na_endereco_out, na_custo_out, atualizado_out, erro_out, expirou_out} !== 16'h0) begin
      fails++; $display("FAIL reset_idle got %h exp 0", {na_ativo_out, na_endereco_out, na_custo_out, atualizado_out, erro_out, expirou_out});
    end
  endtask

  task automatic test_load();
    habilitar_in = 1'b1; endereco_in = 5'd5; custo_in = 8'd20;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b1) begin fails++; $display("FAIL load_ativo got %0d exp 1", na_ativo_out); end
    tests++; if (na_endereco_out !== 5'd5) begin fails++; $display("FAIL load_addr got %0d exp 5", na_endereco_out); end
    tests++; if (na_custo_out !== 8'd20) begin fails++; $display("FAIL load_cost got %0d exp 20", na_custo_out); end
    tests++; if (erro_out !== 1'b0) begin fails++; $display("FAIL load_erro got %0d exp 0", erro_out); end
  endtask

  task automatic test_relax();
    atualizar_in = 1'b1; endereco_in = 5'd5; custo_in = 8'd12;
    tick();
    idle_inputs();
    tests++; if (na_custo_out !== 8'd12) begin fails++; $display("FAIL relax_cost got %0d exp 12", na_custo_out); end
    tests++; if (atualizado_out !== 1'b1) begin fails++; $display("FAIL relax_pulse got %0d exp 1", atualizado_out); end
    tick();
    tests++; if (atualizado_out !== 1'b0) begin fails++; $display("FAIL relax_pulse_end got %0d exp 0", atualizado_out); end
    atualizar_in = 1'b1; endereco_in = 5'd5; custo_in = 8'd15;
    tick();
    idle_inputs();
    tests++; if (na_custo_out !== 8'd12) begin fails++; $display("FAIL relax_higher_cost got %0d exp 12", na_custo_out); end
    tests++; if (atualizado_out !== 1'b0) begin fails++; $display("FAIL relax_higher_pulse got %0d exp 0", atualizado_out); end
    atualizar_in = 1'b1; endereco_in = 5'd5; custo_in = 8'd12;
    tick();
    idle_inputs();
    tests++; if (atualizado_out !== 1'b0) begin fails++; $display("FAIL relax_equal_pulse got %0d exp 0", atualizado_out); end
    atualizar_in = 1'b1; endereco_in = 5'd9; custo_in = 8'd1;
    tick();
    idle_inputs();
    tests++; if (na_custo_out !== 8'd12) begin fails++; $display("FAIL relax_other_addr got %0d exp 12", na_custo_out); end
    tests++; if (atualizado_out !== 1'b0) begin fails++; $display("FAIL relax_other_pulse got %0d exp 0", atualizado_out); end
    desativar_in = 1'b1; endereco_in = 5'd6;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b1) begin fails++; $display("FAIL nonmatch_desativar got %0d exp 1", na_ativo_out); end
  endtask

  task automatic test_collision();
    habilitar_in = 1'b1; endereco_in = 5'd7; custo_in = 8'd3;
    tick();
    tests++; if (erro_out !== 1'b1) begin fails++; $display("FAIL collision_erro1 got %0d exp 1", erro_out); end
    tick();
    idle_inputs();
    tests++; if (erro_out !== 1'b1) begin fails++; $display("FAIL collision_erro2 got %0d exp 1", erro_out); end
    tests++; if (na_endereco_out !== 5'd5) begin fails++; $display("FAIL collision_addr got %0d exp 5", na_endereco_out); end
    tests++; if (na_custo_out !== 8'd12) begin fails++; $display("FAIL collision_cost got %0d exp 12", na_custo_out); end
    tick();
    tests++; if (erro_out !== 1'b0) begin fails++; $display("FAIL collision_erro_end got %0d exp 0", erro_out); end
  endtask

  task automatic test_priority();
    atualizar_in = 1'b1; desativar_in = 1'b1; endereco_in = 5'd5; custo_in = 8'd1;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b0) begin fails++; $display("FAIL prio_ativo got %0d exp 0", na_ativo_out); end
    tests++; if (na_endereco_out !== 5'd0) begin fails++; $display("FAIL prio_addr got %0d exp 0", na_endereco_out); end
    tests++; if (na_custo_out !== 8'd0) begin fails++; $display("FAIL prio_cost got %0d exp 0", na_custo_out); end
    tests++; if (atualizado_out !== 1'b0) begin fails++; $display("FAIL prio_pulse got %0d exp 0", atualizado_out); end
  endtask

  task automatic test_back_to_back();
    habilitar_in = 1'b1; desativar_in = 1'b1; atualizar_in = 1'b1; endereco_in = 5'd4; custo_in = 8'd30;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b1) begin fails++; $display("FAIL b2b_load_ativo got %0d exp 1", na_ativo_out); end
    tests++; if (na_endereco_out !== 5'd4) begin fails++; $display("FAIL b2b_load_addr got %0d exp 4", na_endereco_out); end
    tests++; if (na_custo_out !== 8'd30) begin fails++; $display("FAIL b2b_load_cost got %0d exp 30", na_custo_out); end
    desativar_in = 1'b1; endereco_in = 5'd4;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b0) begin fails++; $display("FAIL b2b_free got %0d exp 0", na_ativo_out); end
  endtask

  task automatic test_reset_mid();
    habilitar_in = 1'b1; endereco_in = 5'd5; custo_in = 8'd40;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b1) begin fails++; $display("FAIL mid_preload got %0d exp 1", na_ativo_out); end
    #2 rst_n = 1'b1;
    #1;
    tests++; if ({na_ativo_out, na_endereco_out, na_custo_out} !== 14'h0) begin
      fails++; $display("FAIL mid_async got %h exp 0", {na_ativo_out, na_endereco_out, na_custo_out});
    end
    habilitar_in = 1'b1;
    tick();
    tests++; if (na_ativo_out !== 1'b0) begin fails++; $display("FAIL mid_strobe_discard got %0d exp 0", na_ativo_out); end
    idle_inputs();
    rst_n = 1'b0;
    tick();
  endtask

`ifdef NO_ATIVO_TIMEOUT_EN
  task automatic test_timeout();
    habilitar_in = 1'b1; endereco_in = 5'd3; custo_in = 8'd50;
    tick();
    idle_inputs();
    repeat (7) tick();
    tests++; if (na_ativo_out !== 1'b1) begin fails++; $display("FAIL to_cycle8_ativo got %0d exp 1", na_ativo_out); end
    tick();
    tests++; if (na_ativo_out !== 1'b0) begin fails++; $display("FAIL to_release got %0d exp 0", na_ativo_out); end
    tests++; if (expirou_out !== 1'b1) begin fails++; $display("FAIL to_expirou got %0d exp 1", expirou_out); end
    tests++; if (na_endereco_out !== 5'd0) begin fails++; $display("FAIL to_addr got %0d exp 0", na_endereco_out); end
    tick();
    tests++; if (expirou_out !== 1'b0) begin fails++; $display("FAIL to_expirou_end got %0d exp 0", expirou_out); end
    habilitar_in = 1'b1; endereco_in = 5'd3; custo_in = 8'd50;
    tick();
    idle_inputs();
    repeat (5) tick();
    atualizar_in = 1'b1; endereco_in = 5'd3; custo_in = 8'd60;
    tick();
    idle_inputs();
    repeat (7) tick();
    tests++; if (na_ativo_out !== 1'b1) begin fails++; $display("FAIL to_delay_cycle14 got %0d exp 1", na_ativo_out); end
    tests++; if (expirou_out !== 1'b0) begin fails++; $display("FAIL to_delay_early got %0d exp 0", expirou_out); end
    tick();
    tests++; if (na_ativo_out !== 1'b0) begin fails++; $display("FAIL to_delay_release got %0d exp 0", na_ativo_out); end
    tests++; if (expirou_out !== 1'b1) begin fails++; $display("FAIL to_delay_expirou got %0d exp 1", expirou_out); end
  endtask
`else
  task automatic test_timeout();
    int ok_cnt;
    habilitar_in = 1'b1; endereco_in = 5'd3; custo_in = 8'd50;
    tick();
    idle_inputs();
    ok_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (na_ativo_out === 1'b1 && expirou_out === 1'b0) ok_cnt++;
    end
    tests++; if (ok_cnt !== 100) begin fails++; $display("FAIL no_timeout got %0d good cycles exp 100", ok_cnt); end
    desativar_in = 1'b1; endereco_in = 5'd3;
    tick();
    idle_inputs();
    tests++; if (na_ativo_out !== 1'b0) begin fails++; $display("FAIL no_timeout_free got %0d exp 0", na_ativo_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_relax();
    test_collision();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
